// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if -- signal bundle between the decode stage, the ID/EX
// pipeline register, the ALU and the two writeback buses.
//
//   master : the surrounding pipeline (drives decode fields, stall/flush
//            and the EX/MEM and MEM/WB writeback buses; receives the
//            EX-side outputs)
//   slave  : the ID/EX stage itself
//
// Decode side : id_valid, id_alu_opcode, id_rs/rt_addr, id_rs/rt_used,
//               id_rs/rt_data, id_imm, id_shamt, id_x_sel, id_y_sel,
//               id_reg_we, id_waddr, id_mem_read, id_ready
// Control     : ex_stall, flush
// Writeback   : mem_reg_we/waddr/wdata, wb_reg_we/waddr/wdata
// EX side     : ex_valid, alu_opcode, alu_op_x, alu_op_y, ex_store_data,
//               ex_reg_we, ex_waddr, ex_mem_read
interface id_ex_stage_if;
    logic        id_valid;
    logic [3:0]  id_alu_opcode;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic        id_x_sel;
    logic        id_y_sel;
    logic        id_reg_we;
    logic [4:0]  id_waddr;
    logic        id_mem_read;
    logic        ex_stall;
    logic        flush;
    logic        mem_reg_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        wb_reg_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        id_ready;
    logic        ex_valid;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_op_x;
    logic [31:0] alu_op_y;
    logic [31:0] ex_store_data;
    logic        ex_reg_we;
    logic [4:0]  ex_waddr;
    logic        ex_mem_read;

    modport master (
        output id_valid, id_alu_opcode, id_rs_addr, id_rt_addr, id_rs_used,
               id_rt_used, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_x_sel, id_y_sel, id_reg_we, id_waddr, id_mem_read,
               ex_stall, flush, mem_reg_we, mem_waddr, mem_wdata,
               wb_reg_we, wb_waddr, wb_wdata,
        input  id_ready, ex_valid, alu_opcode, alu_op_x, alu_op_y,
               ex_store_data, ex_reg_we, ex_waddr, ex_mem_read
    );

    modport slave (
        input  id_valid, id_alu_opcode, id_rs_addr, id_rt_addr, id_rs_used,
               id_rt_used, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_x_sel, id_y_sel, id_reg_we, id_waddr, id_mem_read,
               ex_stall, flush, mem_reg_we, mem_waddr, mem_wdata,
               wb_reg_we, wb_waddr, wb_wdata,
        output id_ready, ex_valid, alu_opcode, alu_op_x, alu_op_y,
               ex_store_data, ex_reg_we, ex_waddr, ex_mem_read
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection,
// stall/flush control and operand forwarding from the EX/MEM and MEM/WB
// writeback buses.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every stage field
//   bus   : id_ex_stage_if.slave (decode inputs, stall/flush, writeback
//           buses in; id_ready and EX-side operands/control out)
module id_ex_stage (
    input  logic           clk,
    input  logic           rst_n,
    id_ex_stage_if.slave   bus
);

    typedef struct packed {
        logic [3:0]  opcode;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        x_sel;
        logic        y_sel;
        logic        reg_we;
        logic [4:0]  waddr;
        logic        mem_read;
        logic        valid;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    logic        hazard;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // A load in EX cannot supply its data until it reaches MEM, so a
    // dependent decode instruction must wait one cycle.
    assign hazard = stage_q.valid && stage_q.mem_read && (stage_q.waddr != 5'd0) &&
                    ((bus.id_rs_used && (bus.id_rs_addr == stage_q.waddr)) ||
                     (bus.id_rt_used && (bus.id_rt_addr == stage_q.waddr)));

    // A flush discards whatever the hazard was protecting, so it overrides it.
    assign bus.id_ready = !bus.ex_stall && (bus.flush || !hazard);

    always_comb begin
        // NOTE: start from the held value so every path assigns stage_d and
        // no latch is inferred.
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d.valid = 1'b0;
        end else if (bus.ex_stall) begin
            // Retiring writes would otherwise be gone before the stall ends.
            if (bus.wb_reg_we && (bus.wb_waddr != 5'd0) && (bus.wb_waddr == stage_q.rs_addr))
                stage_d.rs_data = bus.wb_wdata;
            if (bus.wb_reg_we && (bus.wb_waddr != 5'd0) && (bus.wb_waddr == stage_q.rt_addr))
                stage_d.rt_data = bus.wb_wdata;
        end else if (hazard) begin
            stage_d.valid = 1'b0;
        end else begin
            stage_d.opcode   = bus.id_alu_opcode;
            stage_d.rs_addr  = bus.id_rs_addr;
            stage_d.rt_addr  = bus.id_rt_addr;
            stage_d.rs_data  = bus.id_rs_data;
            stage_d.rt_data  = bus.id_rt_data;
            stage_d.imm      = bus.id_imm;
            stage_d.shamt    = bus.id_shamt;
            stage_d.x_sel    = bus.id_x_sel;
            stage_d.y_sel    = bus.id_y_sel;
            stage_d.reg_we   = bus.id_reg_we;
            stage_d.waddr    = bus.id_waddr;
            stage_d.mem_read = bus.id_mem_read;
            stage_d.valid    = bus.id_valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    // The newer producer (EX/MEM) wins over MEM/WB; r0 is hard-wired zero
    // and is never forwarded.
    always_comb begin
        fwd_rs = stage_q.rs_data;
        if (bus.mem_reg_we && (bus.mem_waddr != 5'd0) && (bus.mem_waddr == stage_q.rs_addr))
            fwd_rs = bus.mem_wdata;
        else if (bus.wb_reg_we && (bus.wb_waddr != 5'd0) && (bus.wb_waddr == stage_q.rs_addr))
            fwd_rs = bus.wb_wdata;
    end

    always_comb begin
        fwd_rt = stage_q.rt_data;
        if (bus.mem_reg_we && (bus.mem_waddr != 5'd0) && (bus.mem_waddr == stage_q.rt_addr))
            fwd_rt = bus.mem_wdata;
        else if (bus.wb_reg_we && (bus.wb_waddr != 5'd0) && (bus.wb_waddr == stage_q.rt_addr))
            fwd_rt = bus.wb_wdata;
    end

    assign bus.ex_valid      = stage_q.valid;
    assign bus.alu_opcode    = stage_q.opcode;
    assign bus.alu_op_x      = stage_q.x_sel ? {27'd0, stage_q.shamt} : fwd_rs;
    assign bus.alu_op_y      = stage_q.y_sel ? stage_q.imm : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_waddr      = stage_q.waddr;
    assign bus.ex_reg_we     = stage_q.valid && stage_q.reg_we;
    assign bus.ex_mem_read   = stage_q.valid && stage_q.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- randomized and directed stimulus for id_ex_stage with a
// queue-based scoreboard. The driver computes the expected EX-side response
// from an instruction-level reference model and queues it; an independent
// monitor pops and compares once per cycle before the rising edge.
module tb_id_ex_stage;

    typedef struct {
        bit        id_valid;
        bit [3:0]  op;
        bit [4:0]  rs, rt;
        bit        rs_used, rt_used;
        bit [31:0] rsd, rtd, imm;
        bit [4:0]  sh;
        bit        xs, ys, we;
        bit [4:0]  wa;
        bit        mr;
        bit        stall, flush;
        bit        mwe;
        bit [4:0]  mwa;
        bit [31:0] mwd;
        bit        wwe;
        bit [4:0]  wwa;
        bit [31:0] wwd;
    } stim_t;

    // Instruction currently occupying EX in the reference model.
    typedef struct {
        bit        valid;
        bit [3:0]  op;
        bit [4:0]  rs, rt;
        bit [31:0] rsd, rtd, imm;
        bit [4:0]  sh;
        bit        xs, ys, we;
        bit [4:0]  wa;
        bit        mr;
    } instr_t;

    typedef struct {
        bit        ready, valid, we, mr;
        bit [3:0]  op;
        bit [4:0]  wa;
        bit [31:0] x, y, st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    exp_t   exp_q[$];
    instr_t m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.id_valid = ($urandom_range(0, 3) != 0);
        s.op       = 4'($urandom);
        s.rs       = 5'($urandom_range(0, 3));
        s.rt       = 5'($urandom_range(0, 3));
        s.rs_used  = 1'($urandom);
        s.rt_used  = 1'($urandom);
        s.rsd      = $urandom;
        s.rtd      = $urandom;
        s.imm      = $urandom;
        s.sh       = 5'($urandom);
        s.xs       = ($urandom_range(0, 3) == 0);
        s.ys       = ($urandom_range(0, 3) == 0);
        s.we       = 1'($urandom);
        s.wa       = 5'($urandom_range(0, 3));
        s.mr       = ($urandom_range(0, 4) < 2);
        s.stall    = ($urandom_range(0, 3) == 0);
        s.flush    = ($urandom_range(0, 9) == 0);
        s.mwe      = 1'($urandom);
        s.mwa      = 5'($urandom_range(0, 3));
        s.mwd      = $urandom;
        s.wwe      = 1'($urandom);
        s.wwa      = 5'($urandom_range(0, 3));
        s.wwd      = $urandom;
        return s;
    endfunction

    // Value of register a as EX should see it: newest in-flight result
    // first, register 0 is always its stored value.
    function automatic bit [31:0] seen(input bit [4:0] a, input bit [31:0] held, input stim_t s);
        if (a == 0)                   return held;
        if (s.mwe && s.mwa == a)      return s.mwd;
        if (s.wwe && s.wwa == a)      return s.wwd;
        return held;
    endfunction

    task automatic apply(input stim_t s);
        bus.id_valid      = s.id_valid;
        bus.id_alu_opcode = s.op;
        bus.id_rs_addr    = s.rs;
        bus.id_rt_addr    = s.rt;
        bus.id_rs_used    = s.rs_used;
        bus.id_rt_used    = s.rt_used;
        bus.id_rs_data    = s.rsd;
        bus.id_rt_data    = s.rtd;
        bus.id_imm        = s.imm;
        bus.id_shamt      = s.sh;
        bus.id_x_sel      = s.xs;
        bus.id_y_sel      = s.ys;
        bus.id_reg_we     = s.we;
        bus.id_waddr      = s.wa;
        bus.id_mem_read   = s.mr;
        bus.ex_stall      = s.stall;
        bus.flush         = s.flush;
        bus.mem_reg_we    = s.mwe;
        bus.mem_waddr     = s.mwa;
        bus.mem_wdata     = s.mwd;
        bus.wb_reg_we     = s.wwe;
        bus.wb_waddr      = s.wwa;
        bus.wb_wdata      = s.wwd;
    endtask

    // One clock cycle: drive, predict, queue the prediction, advance model.
    task automatic cycle(input stim_t s);
        exp_t e;
        bit   load_use;
        bit [31:0] vrs, vrt;
        @(negedge clk);
        apply(s);
        load_use = m.valid && m.mr && m.wa != 0 &&
                   ((s.rs_used && s.rs == m.wa) || (s.rt_used && s.rt == m.wa));
        vrs = seen(m.rs, m.rsd, s);
        vrt = seen(m.rt, m.rtd, s);
        e.ready = !s.stall && (s.flush || !load_use);
        e.valid = m.valid;
        e.we    = m.valid && m.we;
        e.mr    = m.valid && m.mr;
        e.op    = m.op;
        e.wa    = m.wa;
        e.x     = m.xs ? 32'(m.sh) : vrs;
        e.y     = m.ys ? m.imm : vrt;
        e.st    = vrt;
        exp_q.push_back(e);
        if (s.flush) begin
            m.valid = 0;
        end else if (s.stall) begin
            if (s.wwe && s.wwa != 0 && s.wwa == m.rs) m.rsd = s.wwd;
            if (s.wwe && s.wwa != 0 && s.wwa == m.rt) m.rtd = s.wwd;
        end else if (load_use) begin
            m.valid = 0;
        end else begin
            m = '{valid: s.id_valid, op: s.op, rs: s.rs, rt: s.rt, rsd: s.rsd,
                  rtd: s.rtd, imm: s.imm, sh: s.sh, xs: s.xs, ys: s.ys,
                  we: s.we, wa: s.wa, mr: s.mr};
        end
    endtask

    // Caller is positioned just after a monitor slot, so the queue is empty.
    task automatic do_reset();
        rst_n = 1'b0;
        apply(idle_stim());
        m = '{default: 0};
        #1;
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_ex_reg_we", 32'(bus.ex_reg_we), 32'd0);
        check("rst_ex_mem_read", 32'(bus.ex_mem_read), 32'd0);
        check("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares the DUT against queued predictions each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("id_ready", 32'(bus.id_ready), 32'(e.ready));
                check("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
                check("ex_reg_we", 32'(bus.ex_reg_we), 32'(e.we));
                check("ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
                if (e.valid) begin
                    check("alu_opcode", 32'(bus.alu_opcode), 32'(e.op));
                    check("ex_waddr", 32'(bus.ex_waddr), 32'(e.wa));
                    check("alu_op_x", bus.alu_op_x, e.x);
                    check("alu_op_y", bus.alu_op_y, e.y);
                    check("ex_store_data", bus.ex_store_data, e.st);
                end
            end
        end
    end

    initial begin
        stim_t s, s0;
        apply(idle_stim());
        m = '{default: 0};
        #1;
        check("init_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("init_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture: ADD r1(5), r2(7).
        s = idle_stim();
        s.id_valid = 1; s.op = 4'd0; s.rs = 5'd1; s.rt = 5'd2; s.rsd = 5; s.rtd = 7;
        s.we = 1; s.wa = 5'd4;
        cycle(s);
        cycle(idle_stim());
        #4;
        check("cap_x", bus.alu_op_x, 32'd5);
        check("cap_y", bus.alu_op_y, 32'd7);
        check("cap_valid", 32'(bus.ex_valid), 32'd1);

        // Forward priority on r3 for both operands.
        s0 = idle_stim();
        s0.id_valid = 1; s0.rs = 5'd3; s0.rt = 5'd3; s0.rsd = 32'h11; s0.rtd = 32'h22;
        cycle(s0);
        s = s0; s.mwe = 1; s.mwa = 5'd3; s.mwd = 32'hAAAA0000;
        s.wwe = 1; s.wwa = 5'd3; s.wwd = 32'h5555;
        cycle(s);
        #4;
        check("fwd_mem_x", bus.alu_op_x, 32'hAAAA0000);
        check("fwd_mem_y", bus.alu_op_y, 32'hAAAA0000);
        s.mwe = 0;
        cycle(s);
        #4;
        check("fwd_wb_x", bus.alu_op_x, 32'h5555);
        check("fwd_wb_y", bus.alu_op_y, 32'h5555);
        s = s0; s.mwe = 1; s.mwa = 5'd0; s.mwd = 32'hDEAD;
        s.wwe = 1; s.wwa = 5'd0; s.wwd = 32'hBEEF;
        cycle(s);
        #4;
        check("fwd_r0_x", bus.alu_op_x, 32'h11);
        check("fwd_r0_y", bus.alu_op_y, 32'h22);

        // Load-use on r8.
        s = idle_stim();
        s.id_valid = 1; s.rs = 5'd1; s.we = 1; s.wa = 5'd8; s.mr = 1;
        cycle(s);
        s0 = idle_stim();
        s0.id_valid = 1; s0.rs = 5'd8; s0.rs_used = 1; s0.rsd = 32'h999; s0.we = 1; s0.wa = 5'd9;
        cycle(s0);
        #4;
        check("lu_ready", 32'(bus.id_ready), 32'd0);
        cycle(s0);
        #4;
        check("lu_bubble", 32'(bus.ex_valid), 32'd0);
        s = s0; s.mwe = 1; s.mwa = 5'd8; s.mwd = 32'h1234;
        cycle(s);
        #4;
        check("lu_valid", 32'(bus.ex_valid), 32'd1);
        check("lu_x", bus.alu_op_x, 32'h1234);

        // Stall refresh of rt (r5) from the MEM/WB bus.
        s = idle_stim();
        s.id_valid = 1; s.op = 4'd2; s.rt = 5'd5; s.rtd = 32'h10;
        cycle(s);
        s = idle_stim(); s.stall = 1; s.wwe = 1; s.wwa = 5'd5; s.wwd = 32'hBEEF;
        cycle(s);
        s.wwe = 0;
        cycle(s);
        cycle(s);
        cycle(idle_stim());
        #4;
        check("refresh_y", bus.alu_op_y, 32'hBEEF);

        // Flush over stall.
        s = idle_stim();
        s.id_valid = 1; s.we = 1; s.wa = 5'd6;
        cycle(s);
        s = idle_stim(); s.flush = 1; s.stall = 1;
        cycle(s);
        cycle(idle_stim());
        #4;
        check("flush_valid", 32'(bus.ex_valid), 32'd0);
        check("flush_reg_we", 32'(bus.ex_reg_we), 32'd0);

        // Asynchronous reset mid-cycle with a live instruction.
        s = idle_stim();
        s.id_valid = 1; s.op = 4'd7; s.we = 1; s.wa = 5'd2;
        cycle(s);
        cycle(idle_stim());
        #4;
        check("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
        do_reset();

        // Randomized traffic, with an occasional reset during a stall.
        for (int i = 0; i < 600; i++) begin
            s = rand_stim();
            cycle(s);
            if (i % 150 == 149) begin
                s = idle_stim(); s.stall = 1;
                cycle(s);
                #4;
                do_reset();
            end
        end

        @(negedge clk);
        #5;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
